// File: rtl/tt_ckh_pkg.sv
// Shared definitions for the strobe-driven 4x8 register calculator.
// Holds the opcode encoding and register-index width.
// Imported by the ALU, the top level and the bench.
package tt_ckh_pkg;

    localparam int REG_IDX_W = 2;
    localparam int NUM_REGS  = 1 << REG_IDX_W;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        OP_LOADI = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_OR    = 3'b100,
        OP_XOR   = 3'b101,
        OP_SHL   = 3'b110,
        OP_READ  = 3'b111
    } op_e;

    // Everything except READ writes the destination register
    function automatic logic op_writes(input op_e op);
        return op != OP_READ;
    endfunction

endpackage

// File: rtl/tt_um_chukin_hassan_korycki_if.sv
// Pin bundle of the tile: command/immediate inputs and display/bidir outputs.
// No timing of its own; carries the tile pins between bench and design.
// No backpressure: commands are edge-strobed, outputs are always valid.
interface tt_um_chukin_hassan_korycki_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Driver side (bench / chip pads)
    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    // Design side
    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_ckh_alu.sv
// Combinational operation unit: y = f(op, a=R[d], b=R[s], imm).
// Zero latency; pure combinational.
// No backpressure; result is consumed on the executing edge.
module tt_ckh_alu
    import tt_ckh_pkg::*;
(
    input  op_e        op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] imm,
    output logic [7:0] y
);

    // Select result; READ passes the source register through for display
    always_comb begin
        y = '0;
        case (op)
            OP_LOADI: y = imm;
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_SHL:   y = {a[6:0], 1'b0};
            OP_READ:  y = b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/tt_um_chukin_hassan_korycki.sv
// Four-register 8-bit calculator executing one command per rising strobe.
// Latency 1 cycle: uo_out updates on the edge that samples the rising strobe.
// No backpressure: a held strobe executes once; further commands need a new rise.
module tt_um_chukin_hassan_korycki
    import tt_ckh_pkg::*;
(
    input  logic clk,
    input  logic rst,
    tt_um_chukin_hassan_korycki_if.slave bus
);

    logic [7:0]           regs [NUM_REGS];
    logic                 str_q;
    logic                 armed;
    logic [7:0]           uo_q;
    logic [7:0]           alu_y;
    logic                 fire;
    op_e                  op;
    logic [REG_IDX_W-1:0] dst;
    logic [REG_IDX_W-1:0] src;
    logic                 unused_ena;

    // ena is a tile-select the design never gates on
    assign unused_ena = bus.ena;

    assign op  = op_e'(bus.ui_in[6:4]);
    assign dst = bus.ui_in[3:2];
    assign src = bus.ui_in[1:0];

    // armed blocks the very first edge after reset, so a strobe that is
    // already high when reset releases must go low and rise again
    assign fire = bus.ui_in[7] && !str_q && armed;

    tt_ckh_alu u_alu (
        .op  (op),
        .a   (regs[dst]),
        .b   (regs[src]),
        .imm (bus.uio_in),
        .y   (alu_y)
    );

    // Register file, strobe edge detector and display register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            str_q <= 1'b0;
            armed <= 1'b0;
            uo_q  <= '0;
        end else begin
            str_q <= bus.ui_in[7];
            armed <= 1'b1;
            if (fire) begin
                if (op_writes(op)) begin
                    regs[dst] <= alu_y;
                end
                uo_q <= alu_y;
            end
        end
    end

    assign bus.uo_out  = uo_q;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_chukin_hassan_korycki.sv
// Scoreboard bench for the strobe-driven register calculator.
// Stimulus pushes the expected uo_out per command; a monitor pops on executing edges.
// Between commands the monitor checks that uo_out holds its last value.
module tb_tt_um_chukin_hassan_korycki;
    import tt_ckh_pkg::*;

    logic clk;
    logic rst;

    tt_um_chukin_hassan_korycki_if bus ();

    tt_um_chukin_hassan_korycki dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks;
    int n_fail;
    logic [7:0] exp_q [$];
    logic [7:0] hold_exp;
    logic       stim_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: models the rising-strobe detector from the driven pins
    initial begin : monitor
        logic tb_str;
        logic first;
        logic fire;
        logic [7:0] e;
        tb_str = 1'b0;
        first  = 1'b1;
        forever begin
            @(posedge clk);
            if (rst) begin
                fire   = 1'b0;
                tb_str = 1'b0;
                first  = 1'b1;
            end else begin
                fire   = bus.ui_in[7] && !tb_str && !first;
                tb_str = bus.ui_in[7];
                first  = 1'b0;
            end
            #1;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_exec: uo_out=0x%02h with empty scoreboard at %0t", bus.uo_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_result", bus.uo_out, e);
                    hold_exp = e;
                end
            end else begin
                check("hold", bus.uo_out, hold_exp);
            end
            check("uio_out_const", bus.uio_out, 8'h00);
            check("uio_oe_const", bus.uio_oe, 8'h00);
        end
    end

    // Issue one command; strobe rises at a negedge and stays high for hold cycles
    task automatic cmd(input op_e op, input logic [1:0] d, input logic [1:0] s,
                       input logic [7:0] imm, input logic [7:0] exp, input int hold = 1);
        @(negedge clk);
        bus.ui_in  = {1'b0, op, d, s};
        bus.uio_in = imm;
        @(negedge clk);
        bus.ui_in[7] = 1'b1;
        exp_q.push_back(exp);
        repeat (hold) @(negedge clk);
        // scramble non-strobe inputs; they must be ignored while idle
        bus.ui_in  = {1'b0, 7'($urandom_range(0, 127))};
        bus.uio_in = 8'($urandom_range(0, 255));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        n_checks   = 0;
        n_fail     = 0;
        hold_exp   = 8'h00;
        stim_done  = 1'b0;
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        #1;
        check("reset_uo_out", bus.uo_out, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state of every register
        for (int i = 0; i < 4; i++) cmd(OP_READ, 2'd0, 2'(i), 8'h00, 8'h00);

        // Load and wrapped add
        cmd(OP_LOADI, 2'd0, 2'd0, 8'hF0, 8'hF0);
        cmd(OP_LOADI, 2'd1, 2'd0, 8'h20, 8'h20);
        cmd(OP_ADD,   2'd0, 2'd1, 8'h55, 8'h10);

        // Subtract wrap
        cmd(OP_LOADI, 2'd2, 2'd0, 8'h05, 8'h05);
        cmd(OP_LOADI, 2'd3, 2'd0, 8'h07, 8'h07);
        cmd(OP_SUB,   2'd2, 2'd3, 8'h00, 8'hFE);

        // Held strobe, d==s doubles once only
        cmd(OP_LOADI, 2'd1, 2'd0, 8'h03, 8'h03);
        cmd(OP_ADD,   2'd1, 2'd1, 8'h00, 8'h06, 5);
        cmd(OP_READ,  2'd0, 2'd1, 8'h00, 8'h06);

        // Logic ops and shift
        cmd(OP_LOADI, 2'd0, 2'd0, 8'hAA, 8'hAA);
        cmd(OP_LOADI, 2'd1, 2'd0, 8'h0F, 8'h0F);
        cmd(OP_AND,   2'd0, 2'd1, 8'h00, 8'h0A);
        cmd(OP_OR,    2'd0, 2'd1, 8'h00, 8'h0F);
        cmd(OP_XOR,   2'd0, 2'd1, 8'h00, 8'h00);
        cmd(OP_LOADI, 2'd1, 2'd0, 8'h81, 8'h81);
        cmd(OP_SHL,   2'd1, 2'd3, 8'h00, 8'h02);

        // READ leaves registers intact
        cmd(OP_READ,  2'd0, 2'd2, 8'h00, 8'hFE);
        cmd(OP_READ,  2'd1, 2'd3, 8'h00, 8'h07);

        // Mid-run reset with a pending command and strobe held through release
        @(negedge clk);
        bus.ui_in  = {1'b0, OP_LOADI, 2'd3, 2'd0};
        bus.uio_in = 8'h99;
        @(negedge clk);
        bus.ui_in[7] = 1'b1;
        #2;
        rst      = 1'b1;
        hold_exp = 8'h00;
        #1;
        check("async_reset_uo_out", bus.uo_out, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus.ui_in[7] = 1'b0;
        for (int i = 0; i < 4; i++) cmd(OP_READ, 2'd0, 2'(i), 8'h00, 8'h00);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
